uart_rx_fifo: RTL and testbench

Byte-level UART receiver with a small first-word-fall-through FIFO. It deserialises one asynchronous serial line (GPS NMEA stream or LoRa module output) and presents bytes over a valid/ready interface. It sits directly upstream of the sentence/packet parsers (`gps_get`, `lora_rx`) and replaces their ad-hoc bit sampling. Framing errors, glitches and overflow are detected and flagged, not passed downstream.

---
 rtl/uart_rx_fifo.sv | 152 +++++++++++++++
 tb/tb_uart_rx_fifo.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_fifo.sv
// 8N1 UART receiver with 16x oversampling and majority voting, feeding a
// first-word-fall-through FIFO with valid/ready output and error pulses.
module uart_rx_fifo #(
  parameter int CLK_FREQ   = 50_000_000,
  parameter int BAUD       = 9600,
  parameter int FIFO_DEPTH = 8
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          rx,
  output logic [7:0]                    rx_data,
  output logic                          rx_valid,
  input  logic                          rx_ready,
  output logic                          frame_err,
  output logic                          overflow,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);
  localparam int DIV_RAW = (CLK_FREQ + BAUD * 8) / (BAUD * 16);
  localparam int DIV     = (DIV_RAW < 1) ? 1 : DIV_RAW;
  localparam int TW      = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int AW      = $clog2(FIFO_DEPTH);
  localparam int CW      = AW + 1;
  localparam logic [TW-1:0] TICK_LAST = TW'(DIV - 1);
  localparam logic [CW-1:0] FULL_CNT  = CW'(FIFO_DEPTH);

  typedef enum logic [2:0] {IDLE, START, DATA, STOP, BRK} state_t;

  logic          rx_meta, rx_s, rx_prev;
  logic [1:0]    sync_fill;
  logic [TW-1:0] tick_cnt;
  logic          tick, bit_tick, maj;
  logic [3:0]    phase;
  logic          smp7, smp8;
  logic [2:0]    bit_idx;
  logic [7:0]    shreg;
  state_t        state_q, state_n;
  logic          start_det, push, ferr_set;

  logic [7:0]    mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic          full, pop, push_ok;

  // rx_prev stays low until the synchroniser holds real line values, so a
  // line that is low at reset release is not mistaken for a start edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      rx_meta   <= 1'b1;
      rx_s      <= 1'b1;
      rx_prev   <= 1'b0;
      sync_fill <= 2'd0;
    end else begin
      rx_meta <= rx;
      rx_s    <= rx_meta;
      if (sync_fill != 2'd2) sync_fill <= sync_fill + 2'd1;
      rx_prev <= (sync_fill == 2'd2) ? rx_s : 1'b0;
    end
  end

  assign tick     = (tick_cnt == TICK_LAST);
  assign bit_tick = tick && (phase == 4'd9);
  assign maj      = (smp7 & smp8) | (smp7 & rx_s) | (smp8 & rx_s);

  always_ff @(posedge clk) begin
    if (rst) begin
      tick_cnt <= '0;
      phase    <= 4'd0;
      smp7     <= 1'b1;
      smp8     <= 1'b1;
    end else begin
      if (start_det || tick) tick_cnt <= '0;
      else                   tick_cnt <= tick_cnt + TW'(1);
      if (start_det)   phase <= 4'd0;
      else if (tick)   phase <= phase + 4'd1;
      if (tick && phase == 4'd7) smp7 <= rx_s;
      if (tick && phase == 4'd8) smp8 <= rx_s;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_n;
  end

  always_comb begin
    state_n   = state_q;
    start_det = 1'b0;
    push      = 1'b0;
    ferr_set  = 1'b0;
    case (state_q)
      IDLE:  if (rx_prev && !rx_s) begin
               start_det = 1'b1;
               state_n   = START;
             end
      START: if (bit_tick) state_n = maj ? IDLE : DATA;
      DATA:  if (bit_tick && bit_idx == 3'd7) state_n = STOP;
      STOP:  if (bit_tick) begin
               if (maj) begin
                 push    = 1'b1;
                 state_n = IDLE;
               end else begin
                 ferr_set = 1'b1;
                 state_n  = BRK;
               end
             end
      BRK:   if (rx_s) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      bit_idx <= 3'd0;
      shreg   <= 8'h00;
    end else if (bit_tick) begin
      if (state_q == START) bit_idx <= 3'd0;
      if (state_q == DATA) begin
        shreg   <= {maj, shreg[7:1]};
        bit_idx <= bit_idx + 3'd1;
      end
    end
  end

  assign rx_valid = (fifo_count != '0);
  assign full     = (fifo_count == FULL_CNT);
  assign pop      = rx_valid && rx_ready;
  assign push_ok  = push && (!full || pop);
  assign rx_data  = rx_valid ? mem[rd_ptr] : 8'h00;

  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= shreg;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
      frame_err  <= 1'b0;
      overflow   <= 1'b0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + AW'(1);
      if (pop)     rd_ptr <= rd_ptr + AW'(1);
      case ({push_ok, pop})
        2'b10:   fifo_count <= fifo_count + CW'(1);
        2'b01:   fifo_count <= fifo_count - CW'(1);
        default: fifo_count <= fifo_count;
      endcase
      frame_err <= ferr_set;
      overflow  <= push && full && !pop;
    end
  end
endmodule

// File: tb/tb_uart_rx_fifo.sv
// Scoreboard bench for uart_rx_fifo: stimulus pushes expected bytes into a
// queue, a negedge monitor pops and compares on every accepted handshake.
module tb_uart_rx_fifo;
  localparam int CLK_FREQ = 16_000_000;
  localparam int BAUD     = 100_000;
  localparam int DEPTH    = 8;
  localparam int BITC     = 160;

  logic       clk = 1'b0, rst = 1'b1, rx = 1'b1, rx_ready = 1'b0;
  logic [7:0] rx_data;
  logic       rx_valid, frame_err, overflow;
  logic [3:0] fifo_count;

  always #5 clk = ~clk;

  uart_rx_fifo #(.CLK_FREQ(CLK_FREQ), .BAUD(BAUD), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .rx(rx), .rx_data(rx_data), .rx_valid(rx_valid),
    .rx_ready(rx_ready), .frame_err(frame_err), .overflow(overflow),
    .fifo_count(fifo_count)
  );

  logic [7:0] exp_q[$];
  logic [7:0] mon_exp;
  int n_cmp = 0, n_bad = 0, ferr_cnt = 0, ovf_cnt = 0, push_lat = 0;
  bit rand_rdy = 1'b0;

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk); #1;
      if (rand_rdy) rx_ready = 1'($urandom_range(0, 1));
    end
  endtask

  task automatic send_head(input logic [7:0] b, input int bc);
    rx = 1'b0; step(bc);
    for (int i = 0; i < 8; i++) begin
      rx = b[i]; step(bc);
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input int bc, input bit stop_ok);
    send_head(b, bc);
    rx = stop_ok; step(bc);
  endtask

  task automatic drain(input string name);
    rand_rdy = 1'b0;
    rx_ready = 1'b1;
    for (int i = 0; i < 40 && rx_valid; i++) step(1);
    rx_ready = 1'b0;
    step(2);
    chk({name, "_drained"}, int'(rx_valid), 0);
    chk({name, "_sb_empty"}, exp_q.size(), 0);
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      if (rx_valid && rx_ready) begin
        if (exp_q.size() == 0) chk("pop_unexpected", int'(rx_data), -1);
        else begin
          mon_exp = exp_q.pop_front();
          chk("pop_data", int'(rx_data), int'(mon_exp));
        end
      end
      if (!rx_valid) chk("empty_data_zero", int'(rx_data), 0);
      if (frame_err) ferr_cnt++;
      if (overflow)  ovf_cnt++;
    end
  end

  initial begin
    int f0, o0, exp_ovf, n;
    logic [7:0] b;
    logic [7:0] gp [6] = '{8'h24, 8'h47, 8'h50, 8'h52, 8'h4D, 8'h43};
    int rates [3] = '{160, 155, 165};

    // reset with the line toggling
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1; rx = ~rx;
    end
    chk("rst_valid", int'(rx_valid), 0);
    chk("rst_data", int'(rx_data), 0);
    chk("rst_ferr", int'(frame_err), 0);
    chk("rst_ovf", int'(overflow), 0);
    chk("rst_count", int'(fifo_count), 0);
    rst = 1'b0; rx = 1'b1;
    step(20);

    // single byte, measure push latency from start of stop bit
    exp_q.push_back(8'hA5);
    send_head(8'hA5, BITC);
    rx = 1'b1;
    for (int k = 1; k <= BITC; k++) begin
      step(1);
      if (rx_valid && push_lat == 0) push_lat = k;
    end
    chk("a5_push_in_stop_window", int'(push_lat >= 90 && push_lat <= 110), 1);
    chk("a5_valid", int'(rx_valid), 1);
    chk("a5_data", int'(rx_data), 8'hA5);
    chk("a5_count", int'(fifo_count), 1);
    rx_ready = 1'b1; step(1); rx_ready = 1'b0; step(1);
    chk("a5_pop_valid", int'(rx_valid), 0);
    chk("a5_pop_data", int'(rx_data), 0);
    chk("a5_sb_empty", exp_q.size(), 0);

    // $GPRMC back to back at nominal, +3% and -3% baud
    foreach (rates[r]) begin
      f0 = ferr_cnt; o0 = ovf_cnt;
      foreach (gp[i]) begin
        exp_q.push_back(gp[i]);
        send_byte(gp[i], rates[r], 1'b1);
      end
      step(20);
      chk($sformatf("gprmc_count_bc%0d", rates[r]), int'(fifo_count), 6);
      drain($sformatf("gprmc_bc%0d", rates[r]));
      chk("gprmc_no_ferr", ferr_cnt - f0, 0);
      chk("gprmc_no_ovf", ovf_cnt - o0, 0);
    end

    // glitch rejection, then a clean byte proves the receiver is idle again
    f0 = ferr_cnt;
    rx = 1'b0; step(40); rx = 1'b1; step(400);
    chk("glitch_count", int'(fifo_count), 0);
    chk("glitch_no_ferr", ferr_cnt - f0, 0);
    exp_q.push_back(8'h5A);
    send_byte(8'h5A, BITC, 1'b1);
    step(5);
    drain("post_glitch");

    // framing error with a held-low break, then recovery
    f0 = ferr_cnt;
    send_byte(8'h3C, BITC, 1'b0);
    step(2000);
    rx = 1'b1; step(50);
    chk("ferr_one_pulse", ferr_cnt - f0, 1);
    chk("ferr_fifo_unchanged", int'(fifo_count), 0);
    exp_q.push_back(8'h55);
    send_byte(8'h55, BITC, 1'b1);
    step(5);
    chk("ferr_recover_count", int'(fifo_count), 1);
    drain("ferr_recover");

    // random bytes and baud skew with a randomly stalling consumer
    for (int burst = 0; burst < 2; burst++) begin
      rand_rdy = 1'b1;
      n = $urandom_range(1, 3);
      for (int i = 0; i < n; i++) begin
        b = 8'($urandom);
        exp_q.push_back(b);
        send_byte(b, $urandom_range(155, 165), 1'b1);
      end
      step(5);
      drain("rand_burst");
    end

    // overflow: model accepts while fewer than DEPTH bytes are pending
    o0 = ovf_cnt; exp_ovf = 0; rx_ready = 1'b0;
    for (int v = 1; v <= 9; v++) begin
      if (exp_q.size() < DEPTH) exp_q.push_back(8'(v));
      else exp_ovf++;
      send_byte(8'(v), BITC, 1'b1);
    end
    step(5);
    chk("ovf_count_full", int'(fifo_count), DEPTH);
    chk("ovf_pulses", ovf_cnt - o0, exp_ovf);

    // full FIFO with a pop in the push cycle: push accepted, no overflow
    o0 = ovf_cnt;
    exp_q.push_back(8'h0A);
    send_head(8'h0A, BITC);
    rx = 1'b1;
    step(push_lat - 1);
    rx_ready = 1'b1; step(1); rx_ready = 1'b0;
    step(BITC - push_lat + 5);
    chk("full_pop_count", int'(fifo_count), DEPTH);
    chk("full_pop_no_ovf", ovf_cnt - o0, 0);
    drain("full_pop");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
